// File: rtl/booth_sched_pkg.sv
// Shared types and the Booth digit recoder for the multiplier scheduler.
// Operand/product widths, FSM state encoding and operand bundle.
package booth_sched_pkg;
  localparam int OP_W = 8;
  localparam int P_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  typedef struct packed {
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
  } opnd_t;

  // Radix-8 digit g = {b[3i+2],b[3i+1],b[3i],b[3i-1]} -> multiple of A
  function automatic logic signed [P_W-1:0] booth_pp(
    input logic [3:0]            g,
    input logic signed [P_W-1:0] a1,
    input logic signed [P_W-1:0] a3
  );
    logic signed [P_W-1:0] r;
    unique case (g)
      4'b0000, 4'b1111: r = '0;
      4'b0001, 4'b0010: r = a1;
      4'b0011, 4'b0100: r = a1 <<< 1;
      4'b0101, 4'b0110: r = a3;
      4'b0111:          r = a1 <<< 2;
      4'b1000:          r = -(a1 <<< 2);
      4'b1001, 4'b1010: r = -a3;
      4'b1011, 4'b1100: r = -(a1 <<< 1);
      4'b1101, 4'b1110: r = -a1;
      default:          r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/booth_mult_rr_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr.
// Scan runs from lowest to highest priority so the last hit wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);
  always_comb begin
    int s;
    logic [ID_W-1:0] sel;
    s      = 0;
    sel    = '0;
    gnt    = '0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      sel = ID_W'(s);
      if (req[sel]) begin
        gnt      = '0;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end
endmodule

// File: rtl/radix8_booth_multiplier.sv
// Combinational 8x8 signed radix-8 Booth multiplier.
// Three recoded digits; partial sums wrap mod 2^16 but the total fits.
module radix8_booth_multiplier
  import booth_sched_pkg::*;
(
  input  logic signed [OP_W-1:0] a,
  input  logic signed [OP_W-1:0] b,
  output logic signed [P_W-1:0]  p
);
  logic [OP_W+1:0]       bx;
  logic signed [P_W-1:0] a1;
  logic signed [P_W-1:0] a3;

  assign bx = {b[OP_W-1], b, 1'b0};
  assign a1 = {{(P_W-OP_W){a[OP_W-1]}}, a};
  assign a3 = a1 + (a1 <<< 1);

  assign p = booth_pp(bx[3:0], a1, a3)
           + (booth_pp(bx[6:3], a1, a3) <<< 3)
           + (booth_pp(bx[9:6], a1, a3) <<< 6);
endmodule

// File: rtl/booth_mult_rr_scheduler.sv
// Round-robin sharing of one Booth multiplier among NREQ requesters.
// One transaction in flight: IDLE grant -> CALC -> RESP handshake.
module booth_mult_rr_scheduler
  import booth_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic signed [P_W-1:0]  rsp_p,
  output logic                   busy
);
  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  opnd_t                 opnd;
  logic [NREQ-1:0]       gnt;
  logic [ID_W-1:0]       gnt_id;
  logic signed [P_W-1:0] prod;
  logic [ID_W-1:0]       next_ptr;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  radix8_booth_multiplier u_mul (
    .a (opnd.a),
    .b (opnd.b),
    .p (prod)
  );

  // Grants are suppressed while reset is held so none leaks out early
  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
  assign busy      = (state != IDLE);
  assign next_ptr  = (rsp_id == ID_W'(NREQ - 1)) ? '0 : rsp_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      opnd      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            opnd.a <= req_a[gnt_id*OP_W +: OP_W];
            opnd.b <= req_b[gnt_id*OP_W +: OP_W];
            rsp_id <= gnt_id;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_p     <= prod;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_rr_scheduler.sv
// Self-checking bench for booth_mult_rr_scheduler.
// Directed vectors, multi-cycle sequences and a transaction-level random model.
module tb_booth_mult_rr_scheduler;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         req_valid = '0;
  logic [3:0]         req_ready;
  logic [31:0]        req_a = '0;
  logic [31:0]        req_b = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [1:0]         rsp_id;
  logic signed [15:0] rsp_p;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int idx;
    int a;
    int b;
    int p;
    int stall;
  } vec_t;

  vec_t vt[6];

  booth_mult_rr_scheduler #(.NREQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic put_op(input int idx, input int a, input int b);
    req_a[idx*8 +: 8] = 8'(a);
    req_b[idx*8 +: 8] = 8'(b);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic single(input vec_t v);
    @(negedge clk);
    req_valid        = '0;
    req_valid[v.idx] = 1'b1;
    put_op(v.idx, v.a, v.b);
    rsp_ready = 1'b0;
    #1 chk("vec_grant", req_ready, 1 << v.idx);
    @(posedge clk);
    #1;
    req_valid = '0;
    req_a     = $urandom;
    req_b     = $urandom;
    chk("vec_calc_busy", busy, 1);
    chk("vec_calc_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("vec_valid", rsp_valid, 1);
    chk("vec_p", rsp_p, v.p);
    chk("vec_id", rsp_id, v.idx);
    req_valid = 4'hF;
    repeat (v.stall) begin
      @(posedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_p", rsp_p, v.p);
      chk("hold_id", rsp_id, v.idx);
      chk("hold_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("vec_done_valid", rsp_valid, 0);
    chk("vec_done_busy", busy, 0);
  endtask

  initial begin
    logic signed [7:0] ma[4];
    logic signed [7:0] mb[4];
    int mptr;
    int g;
    int got;
    int expp;
    logic [3:0] v;

    vt[0] = '{0, -8, -5, 40, 0};
    vt[1] = '{1, -128, -128, 16384, 0};
    vt[2] = '{2, -128, 127, -16256, 1};
    vt[3] = '{3, 0, -1, 0, 0};
    vt[4] = '{1, 10, 12, 120, 5};
    vt[5] = '{2, -1, -1, 1, 2};

    // reset state, with requests pending during reset
    req_valid = 4'hF;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_p", rsp_p, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    for (int i = 0; i < 6; i++) single(vt[i]);

    // four simultaneous requesters, back-to-back service
    do_reset();
    @(negedge clk);
    put_op(0, -7, 15);
    put_op(1, 10, 12);
    put_op(2, 4, 7);
    put_op(3, -9, -3);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int ep[4];
      ep = '{-105, 120, 28, 27};
      if (k > 0) @(negedge clk);
      #1 chk("all4_grant", req_ready, 1 << k);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      chk("all4_calc_ready", req_ready, 0);
      @(posedge clk);
      #1;
      chk("all4_valid", rsp_valid, 1);
      chk("all4_id", rsp_id, k);
      chk("all4_p", rsp_p, ep[k]);
      @(posedge clk);
      #1 chk("all4_done", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    // req0 and req2 held continuously alternate
    do_reset();
    @(negedge clk);
    put_op(0, 3, 3);
    put_op(2, 5, 5);
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1 chk("alt_grant", req_ready, (k % 2) ? 4 : 1);
      repeat (3) begin
        @(posedge clk);
        #1 chk("alt_odd_ready", int'(req_ready & 4'b1010), 0);
      end
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;

    // reset while CALC drops the transaction and rr pointer
    @(negedge clk);
    put_op(1, 10, 12);
    req_valid = 4'b0010;
    #1 chk("rstmid_grant", req_ready, 2);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("rstmid_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("rstmid_busy_clr", busy, 0);
    chk("rstmid_valid_clr", rsp_valid, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("rstmid_no_rsp", rsp_valid, 0);
      chk("rstmid_no_p", rsp_p, 0);
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'hF;
    #1 chk("rstmid_from0", req_ready, 1);

    // randomized traffic against a transaction-level model
    do_reset();
    mptr = 0;
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      v = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        ma[i] = 8'($urandom);
        mb[i] = 8'($urandom);
        put_op(i, int'(ma[i]), int'(mb[i]));
      end
      req_valid = v;
      rsp_ready = 1'b0;
      if (v == 4'd0) begin
        #1 chk("rnd_idle", req_ready, 0);
        continue;
      end
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && v[(mptr + k) % 4]) g = (mptr + k) % 4;
      end
      expp = int'(ma[g]) * int'(mb[g]);
      #1 chk("rnd_grant", req_ready, 1 << g);
      @(posedge clk);
      #1;
      req_valid = '0;
      req_a     = $urandom;
      req_b     = $urandom;
      got = 0;
      for (int c = 0; c < 4 && got == 0; c++) begin
        @(posedge clk);
        #1;
        if (rsp_valid) got = 1;
      end
      chk("rnd_rsp_seen", got, 1);
      chk("rnd_id", rsp_id, g);
      chk("rnd_p", rsp_p, expp);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1 chk("rnd_hold_p", rsp_p, expp);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("rnd_done", rsp_valid, 0);
      mptr = (g + 1) % 4;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
